// File: rtl/thresh_sched_ctrl.sv
// Frame threshold scheduler: accumulates the per-frame magnitude sum, divides it to get the mean,
// scales and clamps it into high/low thresholds, and applies them only at the next start of frame.
module thresh_sched_ctrl #(
  parameter int IMG_W    = 512,
  parameter int IMG_H    = 512,
  parameter int DEF_HIGH = 100,
  parameter int MIN_THR  = 16,
  parameter int MAX_THR  = 240,
  parameter int K_MUL    = 6
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic [7:0] i_pixel,
  input  logic       i_sof,
  input  logic       i_mode,
  input  logic [7:0] i_fixed_thr,
  output logic [7:0] o_high_thr,
  output logic [7:0] o_low_thr,
  output logic       o_thr_update,
  output logic       o_busy,
  output logic       o_frame_err
);
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(NPIX) + 1;
  localparam int ACC_W = 8 + $clog2(NPIX);

  localparam logic [ACC_W:0] DIVISOR = (ACC_W+1)'(NPIX);
  localparam logic [11:0]    KMUL12  = 12'(K_MUL);
  localparam logic [9:0]     MIN10   = 10'(MIN_THR);
  localparam logic [9:0]     MAX10   = 10'(MAX_THR);
  localparam logic [7:0]     DEF8    = 8'(DEF_HIGH);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_SCALE, S_PEND} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_pcnt;
  logic [ACC_W-1:0] r_sum;
  logic [ACC_W:0]   r_rem;
  logic [2:0]       r_bit;
  logic [7:0]       r_q;
  logic [7:0]       r_pend;
  logic [7:0]       r_hi;
  logic [7:0]       r_lo;
  logic             r_upd;
  logic             r_busy;
  logic             r_err;

  logic             w_sof;
  logic             w_fend;
  logic             w_ferr;
  logic [CNT_W-1:0] w_pcnt_nxt;
  logic [ACC_W-1:0] w_sum_nxt;
  logic [ACC_W:0]   w_dsh;
  logic             w_ge;
  logic [11:0]      w_prod;
  logic [9:0]       w_s;
  logic [7:0]       w_clamp;

  // A sof pixel restarts the frame, so it seeds the count/sum instead of adding to them.
  always_comb begin
    w_sof      = i_valid & i_sof;
    w_pcnt_nxt = i_sof ? CNT_W'(1) : r_pcnt + CNT_W'(1);
    w_sum_nxt  = i_sof ? ACC_W'(i_pixel) : r_sum + ACC_W'(i_pixel);
    w_fend     = i_valid && (w_pcnt_nxt == CNT_W'(NPIX));
    w_ferr     = w_sof && (r_pcnt != '0);
    w_dsh      = DIVISOR << r_bit;
    w_ge       = (r_rem >= w_dsh);
    w_prod     = 12'(r_q) * KMUL12;
    w_s        = w_prod[11:2];
    w_clamp    = (w_s < MIN10) ? MIN10[7:0] : (w_s > MAX10) ? MAX10[7:0] : w_s[7:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pcnt <= '0;
      r_sum  <= '0;
    end else if (i_valid) begin
      if (w_fend) begin
        r_pcnt <= '0;
        r_sum  <= '0;
      end else begin
        r_pcnt <= w_pcnt_nxt;
        r_sum  <= w_sum_nxt;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_bit   <= '0;
      r_q     <= '0;
      r_pend  <= '0;
      r_hi    <= DEF8;
      r_lo    <= DEF8 >> 1;
      r_upd   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      r_err <= w_ferr;
      if (w_sof) begin
        if (!i_mode) begin
          r_hi  <= i_fixed_thr;
          r_lo  <= i_fixed_thr >> 1;
          r_upd <= 1'b1;
        end else if (r_state == S_PEND) begin
          r_hi  <= r_pend;
          r_lo  <= r_pend >> 1;
          r_upd <= (r_pend != r_hi);
        end
      end
      case (r_state)
        S_IDLE, S_PEND: begin
          if (w_fend) begin
            r_rem   <= {1'b0, w_sum_nxt};
            r_bit   <= 3'd7;
            r_q     <= '0;
            r_busy  <= 1'b1;
            r_state <= S_DIV;
          end else if (w_sof) begin
            r_state <= S_IDLE;
          end
        end
        S_DIV: begin
          if (w_ge) r_rem <= r_rem - w_dsh;
          r_q <= {r_q[6:0], w_ge};
          if (r_bit == 3'd0) r_state <= S_SCALE;
          else               r_bit   <= r_bit - 3'd1;
        end
        S_SCALE: begin
          r_pend  <= w_clamp;
          r_busy  <= 1'b0;
          r_state <= S_PEND;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_high_thr   = r_hi;
  assign o_low_thr    = r_lo;
  assign o_thr_update = r_upd;
  assign o_busy       = r_busy;
  assign o_frame_err  = r_err;
endmodule

// File: tb/tb_thresh_sched_ctrl.sv
// Directed bench for thresh_sched_ctrl on an 8-pixel frame (4x2).
module tb_thresh_sched_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] pixel = '0;
  logic       sof = 1'b0;
  logic       mode = 1'b1;
  logic [7:0] fixed_thr = '0;
  logic [7:0] hi, lo;
  logic       upd, busy, ferr;
  int total = 0;
  int bad = 0;
  int busy_cnt = 0;

  thresh_sched_ctrl #(.IMG_W(4), .IMG_H(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_pixel(pixel), .i_sof(sof),
    .i_mode(mode), .i_fixed_thr(fixed_thr), .o_high_thr(hi), .o_low_thr(lo),
    .o_thr_update(upd), .o_busy(busy), .o_frame_err(ferr)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (busy) busy_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic px(input logic s, input logic [7:0] p);
    @(negedge clk);
    valid = 1'b1; sof = s; pixel = p;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid = 1'b0; sof = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic frame(input logic [7:0] base, input int inc, input int n, input bit s,
                       input bit gap, input logic [7:0] ehi, input bit eupd, input bit eerr);
    for (int k = 0; k < n; k++) begin
      if (gap) idle($urandom_range(0, 2));
      px(s && (k == 0), 8'(int'(base) + inc * k));
      chk("high", int'(hi), int'(ehi));
      if (k == 0) begin
        chk("low", int'(lo), int'(ehi >> 1));
        chk("upd", int'(upd), int'(eupd));
        chk("ferr", int'(ferr), int'(eerr));
      end else if (k == 1) begin
        chk("upd_clr", int'(upd), 0);
        chk("ferr_clr", int'(ferr), 0);
      end
    end
  endtask

  initial begin
    #12;
    chk("rst_high", int'(hi), 100);
    chk("rst_low", int'(lo), 50);
    chk("rst_upd", int'(upd), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ferr", int'(ferr), 0);
    @(negedge clk); rst_n = 1'b1;

    // mean 80 -> 120/60, busy for DIV+SCALE
    busy_cnt = 0;
    frame(8'd80, 0, 8, 1, 0, 8'd100, 0, 0);
    idle(14);
    chk("busy_cycles", busy_cnt, 9);
    chk("hold_before_sof", int'(hi), 100);
    // apply 120; ramp 0..7 -> mean 3 -> low clamp 16
    frame(8'd0, 1, 8, 1, 0, 8'd120, 1, 0);
    idle(14);
    chk("hold_120", int'(hi), 120);
    frame(8'd255, 0, 8, 1, 0, 8'd16, 1, 0);
    idle(14);
    // apply 240 (upper clamp), partial frame of 5 then restart
    frame(8'd40, 0, 5, 1, 0, 8'd240, 1, 0);
    idle(2);
    frame(8'd40, 0, 8, 1, 0, 8'd240, 0, 1);
    idle(14);
    frame(8'd100, 0, 8, 1, 0, 8'd60, 1, 0);
    idle(14);

    // fixed mode, fixed value changed mid-frame
    mode = 1'b0; fixed_thr = 8'd200;
    frame(8'd100, 0, 4, 1, 0, 8'd200, 1, 0);
    fixed_thr = 8'd50;
    frame(8'd100, 0, 4, 0, 0, 8'd200, 0, 0);
    idle(14);
    chk("fixed_hold", int'(hi), 200);
    frame(8'd100, 0, 8, 1, 0, 8'd50, 1, 0);

    // reset mid-DIV
    idle(3);
    chk("busy_in_div", int'(busy), 1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("mid_rst_high", int'(hi), 100);
    chk("mid_rst_low", int'(lo), 50);
    chk("mid_rst_busy", int'(busy), 0);
    @(negedge clk); rst_n = 1'b1;
    mode = 1'b1;
    // gapped frame after reset: no pending result -> no update
    frame(8'd100, 0, 8, 1, 1, 8'd100, 0, 0);
    idle(14);
    frame(8'd100, 0, 8, 1, 0, 8'd150, 1, 0);
    idle(14);
    // same value again -> no pulse
    frame(8'd40, 0, 8, 1, 0, 8'd150, 0, 0);
    idle(14);
    frame(8'd0, 0, 1, 1, 0, 8'd60, 1, 0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
